k423_if_fetch_queue: RTL

//  Instruction fetch queue. Sits between the fetch unit (imem response + BPU prediction) and the IF/ID pipeline register.

---
 rtl/k423_pkg.sv | 12 +
 rtl/k423_if_fetch_queue.sv | 75 +++++++
 2 files changed

// File: rtl/k423_pkg.sv
// k423_pkg: shared core widths and the fetch-queue / IF-ID payload entry type
package k423_pkg;
  localparam int CORE_ADDR_W = 32;
  localparam int CORE_INST_W = 32;
  typedef struct packed {
    logic [CORE_ADDR_W-1:0] pc;
    logic [CORE_INST_W-1:0] inst;
    logic                   bpu_prd_tkn;
    logic [CORE_ADDR_W-1:0] bpu_prd_pc;
    logic [1:0]             bpu_prd_sat_cnt;
  } ifq_entry_t;
endpackage

// File: rtl/k423_if_fetch_queue.sv
// k423_if_fetch_queue: instruction fetch queue between the fetch unit and the IF/ID register.
//   clk_i/rst_n_i                 clock, async active-low reset
//   pcu_clear_if_id_i             flush all entries, drop this cycle's push/pop
//   pcu_stall_if_id_i             hold head, suppress pop
//   fetch_*_i / fetch_rdy_o       push side (instruction + BPU prediction)
//   if_*_o / id_stage_rdy_i       pop side valid/ready toward IF/ID
//   ifq_cnt_o                     occupancy 0..DEPTH
// Optional macro K423_IFQ_BYPASS_EN: empty-queue fetch goes straight to the head outputs.
module k423_if_fetch_queue
  import k423_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   pcu_clear_if_id_i,
  input  logic                   pcu_stall_if_id_i,
  input  logic                   fetch_vld_i,
  output logic                   fetch_rdy_o,
  input  logic [CORE_ADDR_W-1:0] fetch_pc_i,
  input  logic [CORE_INST_W-1:0] fetch_inst_i,
  input  logic                   fetch_bpu_prd_tkn_i,
  input  logic [CORE_ADDR_W-1:0] fetch_bpu_prd_pc_i,
  input  logic [1:0]             fetch_bpu_prd_sat_cnt_i,
  output logic                   if_stage_vld_o,
  input  logic                   id_stage_rdy_i,
  output logic [CORE_ADDR_W-1:0] if_pc_o,
  output logic [CORE_INST_W-1:0] if_inst_o,
  output logic                   if_bpu_prd_tkn_o,
  output logic [CORE_ADDR_W-1:0] if_bpu_prd_pc_o,
  output logic [1:0]             if_bpu_prd_sat_cnt_o,
  output logic [CNT_W-1:0]       ifq_cnt_o
);
  localparam int IDX_W = CNT_W - 1;
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  ifq_entry_t       mem_q [DEPTH];
  ifq_entry_t       fetch_ent, head;
  logic             empty, byp, push, pop, wr_en, rd_adv;
  assign fetch_ent = {fetch_pc_i, fetch_inst_i, fetch_bpu_prd_tkn_i, fetch_bpu_prd_pc_i, fetch_bpu_prd_sat_cnt_i};
  // Pointers carry a wrap bit, so their difference is the occupancy directly.
  always_comb begin
    ifq_cnt_o   = wr_ptr_q - rd_ptr_q;
    empty       = (wr_ptr_q == rd_ptr_q);
    fetch_rdy_o = (ifq_cnt_o != CNT_W'(DEPTH));
`ifdef K423_IFQ_BYPASS_EN
    byp = empty & fetch_vld_i & ~pcu_clear_if_id_i;
`else
    byp = 1'b0;
`endif
    if_stage_vld_o = ~empty | byp;
    head = ~if_stage_vld_o ? '0 : byp ? fetch_ent : mem_q[rd_ptr_q[IDX_W-1:0]];
    push = fetch_vld_i & fetch_rdy_o & ~pcu_clear_if_id_i;
    pop  = if_stage_vld_o & id_stage_rdy_i & ~pcu_stall_if_id_i & ~pcu_clear_if_id_i;
    // A bypassed entry that is consumed immediately never occupies the array.
    wr_en    = push & ~(byp & pop);
    rd_adv   = pop & ~byp;
    wr_ptr_d = pcu_clear_if_id_i ? '0 : wr_ptr_q + CNT_W'(wr_en);
    rd_ptr_d = pcu_clear_if_id_i ? '0 : rd_ptr_q + CNT_W'(rd_adv);
  end
  assign {if_pc_o, if_inst_o, if_bpu_prd_tkn_o, if_bpu_prd_pc_o, if_bpu_prd_sat_cnt_o} = head;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  // Storage is not reset; reads are gated by the valid flag.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[IDX_W-1:0]] <= fetch_ent;
  end
endmodule
